// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: default geometry and the fetch-queue entry layout shared by the fetch unit.
package fetch_unit_pkg;
    localparam int PC_W_DEF     = 16;
    localparam int INSTR_W_DEF  = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int RESET_PC_DEF = 0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO with synchronous flush; flush wins over push and pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = PC_W_DEF + INSTR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = cnt_q == (AW+1)'(DEPTH);
    assign empty     = cnt_q == '0;
    assign count     = cnt_q;
    assign head_data = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a one-deep in-flight tracker feeding a decode queue.
// Defining FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t                 push_entry, head_entry;
    logic [PC_W-1:0]        pc_q, pc_d, inflight_pc_q;
    logic                   inflight_q, push, pop, full, empty;
    logic [$clog2(DEPTH):0] count;

    assign pop        = out_valid && out_ready;
    assign push       = inflight_q && !redirect_valid && !full;
    // Reserve a slot for the in-flight response so it never finds the queue full.
    assign imem_req   = !rst && !redirect_valid && (int'(count) + int'(inflight_q) - int'(pop) < DEPTH);
    assign imem_addr  = pc_q;
    assign push_entry = {inflight_pc_q, imem_rdata};
    assign out_valid  = !empty;
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;

    always_comb begin
        pc_d = redirect_valid ? redirect_pc : (imem_req ? pc_q + PC_W'(1) : pc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= pc_q;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH),
        .W    (PC_W + INSTR_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head_data(head_entry),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!out_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (redirect_valid && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of startup, backpressure, redirects, PC wrap and mid-run reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address n is 0x1000+n, returned one cycle after the request.
    always @(posedge clk) if (imem_req) imem_rdata <= 16'h1000 + imem_addr;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0077;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            tests++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs k=%0d got req=%b valid=%b want req=0 valid=0", k, imem_req, out_valid);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_startup;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            rst = 1'b0;
            #1;
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
                fails++;
                $display("FAIL startup_req k=%0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 16'(k));
            end
            tests++;
            if (k < 2) begin
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL startup_idle k=%0d got valid=%b want 0", k, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_pc !== 16'(k - 2) || out_instr !== 16'h1000 + 16'(k - 2)) begin
                fails++;
                $display("FAIL startup_out k=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 16'(k - 2), 16'h1000 + 16'(k - 2));
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            rst = 1'b0;
            #1;
            tests++;
            if (imem_req !== (k < 4) || (k < 4 && imem_addr !== 16'(k))) begin
                fails++;
                $display("FAIL bp_req k=%0d got req=%b addr=%h want req=%b addr=%h", k, imem_req, imem_addr, k < 4, 16'(k));
            end
            if (k >= 2) begin
                tests++;
                if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
                    fails++;
                    $display("FAIL bp_head k=%0d got v=%b pc=%h instr=%h want v=1 pc=0000 instr=1000",
                             k, out_valid, out_pc, out_instr);
                end
            end
        end
        for (int j = 0; j < 6; j++) begin
            cyc();
            out_ready = 1'b1;
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 16'(j) || out_instr !== 16'h1000 + 16'(j)) begin
                fails++;
                $display("FAIL bp_drain j=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         j, out_valid, out_pc, out_instr, 16'(j), 16'h1000 + 16'(j));
            end
        end
    endtask

    task automatic test_redirect;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            rst = 1'b0;
        end
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL redir_cycle got req=%b valid=%b want req=0 valid=1", imem_req, out_valid);
        end
        cyc();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            fails++;
            $display("FAIL redir_next got v=%b req=%b addr=%h want v=0 req=1 addr=0040", out_valid, imem_req, imem_addr);
        end
        cyc();
        #1;
        tests++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0041) begin
            fails++;
            $display("FAIL redir_gap got v=%b addr=%h want v=0 addr=0041", out_valid, imem_addr);
        end
        for (int j = 0; j < 3; j++) begin
            cyc();
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 16'h0040 + 16'(j) || out_instr !== 16'h1040 + 16'(j)) begin
                fails++;
                $display("FAIL redir_out j=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         j, out_valid, out_pc, out_instr, 16'h0040 + 16'(j), 16'h1040 + 16'(j));
            end
        end
    endtask

    task automatic test_back_to_back;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        cyc();
        redirect_pc = 16'h0200;
        #1;
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_req got req=%b want 0", imem_req);
        end
        cyc();
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_addr got req=%b addr=%h v=%b want req=1 addr=0200 v=0", imem_req, imem_addr, out_valid);
        end
        cyc();
        cyc();
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0200) begin
            fails++;
            $display("FAIL b2b_out got v=%b pc=%h want v=1 pc=0200", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE;
        exp_pc[1] = 16'hFFFF;
        exp_pc[2] = 16'h0000;
        out_ready = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            redirect_valid = 1'b0;
            #1;
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc[j]) begin
                fails++;
                $display("FAIL wrap_addr j=%0d got req=%b addr=%h want req=1 addr=%h", j, imem_req, imem_addr, exp_pc[j]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[j] || out_instr !== 16'h1000 + exp_pc[j]) begin
                fails++;
                $display("FAIL wrap_out j=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         j, out_valid, out_pc, out_instr, exp_pc[j], 16'h1000 + exp_pc[j]);
            end
            cyc();
            #1;
        end
    endtask

    task automatic test_reset_midop;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            rst = 1'b0;
        end
        cyc();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        #1;
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_req got req=%b want 0", imem_req);
        end
        cyc();
        #1;
        tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_hold got v=%b req=%b want v=0 req=0", out_valid, imem_req);
        end
        cyc();
        rst = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_first got req=%b addr=%h v=%b want req=1 addr=0000 v=0", imem_req, imem_addr, out_valid);
        end
        cyc();
        cyc();
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h1000) begin
            fails++;
            $display("FAIL rstmid_out got v=%b pc=%h instr=%h want v=1 pc=0000 instr=1000", out_valid, out_pc, out_instr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf;
        int  s = 0;
        int  f = 0;
        bit  exp_ov;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            cyc();
            rst = 1'b0;
            redirect_valid = (k == 3 || k == 6 || k == 9);
            redirect_pc = 16'h0300;
            #1;
            exp_ov = !(k < 2 || k == 4 || k == 5 || k == 7 || k == 8 || k == 10 || k == 11);
            tests++;
            if (perf_stall_cnt !== 32'(s) || perf_flush_cnt !== 32'(f) || out_valid !== exp_ov) begin
                fails++;
                $display("FAIL perf k=%0d got stall=%0d flush=%0d v=%b want stall=%0d flush=%0d v=%b",
                         k, perf_stall_cnt, perf_flush_cnt, out_valid, s, f, exp_ov);
            end
            s += int'(!exp_ov);
            f += int'(redirect_valid);
        end
        redirect_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 16, width of fetch addresses and PC.
REQ-002 Parameter INSTR_W, default 16, width of an instruction word.
REQ-003 Parameter DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 imem_req  out  1  read request to instruction memory this cycle.
REQ-008 imem_addr  out  PC_W  word address of the request.
REQ-009 imem_rdata  in  INSTR_W  instruction word, valid exactly one cycle after imem_req.
REQ-010 redirect_valid  in  1  branch/jump redirect (flush) request.
REQ-011 redirect_pc  in  PC_W  new fetch address on redirect.
REQ-012 out_valid  out  1  queue head holds a valid instruction.
REQ-013 out_ready  in  1  decode accepts head; transfer when out_valid && out_ready.
REQ-014 out_pc  out  PC_W  address of head instruction.
REQ-015 out_instr  out  INSTR_W  head instruction word.

Function
REQ-016 The block SHALL hold a fetch PC, a one-deep in-flight tracker (flag plus PC), and a DEPTH-entry FIFO of {pc, instr}.
REQ-017 imem_req SHALL be 1 when not in reset, redirect_valid=0, and count + inflight - pop < DEPTH, where pop = out_valid && out_ready; imem_addr SHALL equal fetch PC.
REQ-018 On an issued request, fetch PC SHALL increment by 1 modulo 2^PC_W (0xFFFF wraps to 0x0000 at PC_W=16).
REQ-019 The response SHALL be written into the FIFO at the end of the cycle after issue, tagged with the issued PC; out_valid SHALL first rise two cycles after issue.
REQ-020 With out_ready held at 1 and no redirect, throughput SHALL be one instruction per cycle.
REQ-021 out_valid, out_pc and out_instr SHALL be driven from the FIFO head only, with no combinational path from imem_rdata.
REQ-022 On redirect_valid=1: fetch PC <= redirect_pc, FIFO emptied, in-flight response discarded, imem_req=0 that cycle; the first request to redirect_pc SHALL issue the next cycle.
REQ-023 Redirect SHALL take priority over a simultaneous pop and push; the head is still considered consumed if out_ready=1.
REQ-024 Back-to-back redirects SHALL each reload fetch PC; only the last one takes effect.
REQ-025 When the FIFO is full, no request SHALL issue and no entry SHALL be overwritten; when it is empty, out_valid=0.
REQ-026 out_pc/out_instr SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While rst=1: imem_req=0, out_valid=0, FIFO count 0, in-flight flag 0, fetch PC=RESET_PC; rst overrides redirect.
REQ-028 The first request SHALL issue in the first cycle with rst=0, to RESET_PC.
REQ-029 A reset asserted mid-operation SHALL discard all queued and in-flight instructions.

Configuration
REQ-030 With macro FETCH_PERF_EN defined: outputs perf_stall_cnt (32-bit, counts cycles with out_valid=0 outside reset) and perf_flush_cnt (32-bit, counts redirect cycles), both cleared by rst and saturating at all-ones.
REQ-031 Without FETCH_PERF_EN: those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-032 A shared package SHALL hold the default PC_W, INSTR_W, DEPTH, RESET_PC, and a packed fetch-entry typedef {pc, instr}.
REQ-033 The FIFO SHALL be a sub-module, fetch_queue (push, pop, flush, full, empty, count), parameterised by DEPTH and entry width.

Verification
REQ-034 Reset release, out_ready=1, imem[n]=0x1000+n -> imem_addr 0,1,2,...; out_valid rises at cycle 2; out_pc=0,1,2 with out_instr=0x1000,0x1001,0x1002 on consecutive cycles.
REQ-035 Backpressure: out_ready=0 for 10 cycles at DEPTH=4 -> exactly 4 entries queued, imem_req=0 while full, head stable; release -> entries pc 0..3 drain in order, no loss or duplicate.
REQ-036 Redirect to 0x0040 while the queue holds 3 entries and 1 is in flight -> out_valid=0 next cycle, imem_addr=0x0040 next cycle, first delivered out_pc=0x0040; no stale pc is delivered.
REQ-037 Redirect to 0xFFFE -> delivered out_pc sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-038 rst pulsed while the queue is full and redirect_valid=1 -> out_valid=0 during reset; after release the first fetch is RESET_PC.
REQ-039 With FETCH_PERF_EN defined: 3 redirects plus the 2-cycle startup -> perf_flush_cnt=3, and perf_stall_cnt increments on every out_valid=0 cycle.
